// File: rtl/tpu_loader_pkg.sv
// Shared TPU loader definitions: default geometry, FSM state type and a counter-width helper.
package tpu_loader_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MATRIX_DIM_DEF = 16;
    localparam int unsigned CONV_DIM_DEF   = 3;
    localparam int unsigned RES_DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_K  = 3'd1,
        ST_LOAD_M  = 3'd2,
        ST_FIRE    = 3'd3,
        ST_COLLECT = 3'd4,
        ST_DRAIN   = 3'd5
    } tpu_state_e;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full+push+pop both proceed, push while full without pop is dropped.
module sync_fifo
    import tpu_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           empty,
    output logic                           full,
    output logic [cnt_width(DEPTH)-1:0]    count
);

    localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tpu_loader.sv
// Streams kernel and matrix bytes into the TPU, fires it, and buffers its results for downstream.
module tpu_loader
    import tpu_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MATRIX_DIM = MATRIX_DIM_DEF,
    parameter int unsigned CONV_DIM   = CONV_DIM_DEF,
    parameter int unsigned RES_DEPTH  = RES_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  insert_kernel,
    output logic                  insert_matrix,
    output logic [DATA_WIDTH-1:0] tpu_data,
    output logic                  tpu_ready,
    input  logic                  tpu_done,
    input  logic [DATA_WIDTH-1:0] tpu_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  busy,
    output logic                  job_done,
    output logic                  overflow
);

    localparam int unsigned K_COUNT = CONV_DIM * CONV_DIM;
    localparam int unsigned M_COUNT = MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned OUT_DIM = MATRIX_DIM - CONV_DIM + 1;
    localparam int unsigned N_RES   = OUT_DIM * OUT_DIM;
    localparam int unsigned LW      = cnt_width((M_COUNT > K_COUNT) ? M_COUNT : K_COUNT);
    localparam int unsigned RW      = cnt_width(N_RES);
    localparam int unsigned CW      = cnt_width(RES_DEPTH);

    tpu_state_e    state;
    tpu_state_e    state_nxt;
    logic [LW-1:0] load_cnt;
    logic [LW-1:0] load_cnt_nxt;
    logic [RW-1:0] res_cnt;
    logic [RW-1:0] res_cnt_nxt;
    logic          start_acc;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;

    assign res_valid = !fifo_empty;
    assign fifo_pop  = res_valid && res_ready;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            load_cnt <= '0;
            res_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            load_cnt <= load_cnt_nxt;
            res_cnt  <= res_cnt_nxt;
        end
    end

    // Sticky overflow, cleared when a new job is accepted.
    always_ff @(posedge clk) begin
        if (rst)                                        overflow <= 1'b0;
        else if (start_acc)                             overflow <= 1'b0;
        else if (fifo_push && fifo_full && !fifo_pop)   overflow <= 1'b1;
    end

    always_comb begin
        state_nxt     = state;
        load_cnt_nxt  = load_cnt;
        res_cnt_nxt   = res_cnt;
        start_acc     = 1'b0;
        src_ready     = 1'b0;
        insert_kernel = 1'b0;
        insert_matrix = 1'b0;
        tpu_data      = '0;
        tpu_ready     = 1'b0;
        fifo_push     = 1'b0;
        job_done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc    = 1'b1;
                    load_cnt_nxt = '0;
                    res_cnt_nxt  = '0;
                    state_nxt    = ST_LOAD_K;
                end
            end
            ST_LOAD_K: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    insert_kernel = 1'b1;
                    tpu_data      = src_data;
                    if (load_cnt == LW'(K_COUNT - 1)) begin
                        load_cnt_nxt = '0;
                        state_nxt    = ST_LOAD_M;
                    end else begin
                        load_cnt_nxt = load_cnt + LW'(1);
                    end
                end
            end
            ST_LOAD_M: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    insert_matrix = 1'b1;
                    tpu_data      = src_data;
                    if (load_cnt == LW'(M_COUNT - 1)) begin
                        load_cnt_nxt = '0;
                        state_nxt    = ST_FIRE;
                    end else begin
                        load_cnt_nxt = load_cnt + LW'(1);
                    end
                end
            end
            ST_FIRE: begin
                tpu_ready = 1'b1;
                state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                // Dropped pushes still count toward the expected result total.
                if (tpu_done) begin
                    fifo_push = 1'b1;
                    if (res_cnt == RW'(N_RES - 1)) begin
                        res_cnt_nxt = '0;
                        state_nxt   = ST_DRAIN;
                    end else begin
                        res_cnt_nxt = res_cnt + RW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty || (fifo_count == CW'(1) && fifo_pop)) begin
                    job_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (tpu_result),
        .rdata (res_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule
